tx_engine: RTL and testbench

UART transmit engine. It is the transmit-side counterpart of the receive engine's remapping stage.
- Accepts a byte on a load strobe.
- Builds an 11-bit frame: start, 7 or 8 data bits, optional odd/even parity, stop padding.
- Shifts the frame out LSB-first on `tx`, holding each bit for a programmable number of clocks.
- Sits between the host/CPU write interface and the serial pin; reports ready/done back to the host.

---
 rtl/uart_pkg.sv | 15 +
 rtl/tx_bit_builder.sv | 21 ++
 rtl/tx_engine.sv | 75 +++++++
 tb/tb_tx_engine.sv | 132 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, mode encoding and engine states
package uart_pkg;
  localparam int FRAME_W = 11;
  localparam int BAUD_W = 20;
  typedef enum logic [1:0] {
    MODE_7N = 2'b00,
    MODE_7P = 2'b01,
    MODE_8N = 2'b10,
    MODE_8P = 2'b11
  } mode_e;
  typedef enum logic {IDLE, SHIFT} state_e;
  localparam logic IDLE_LVL = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/tx_bit_builder.sv
// tx_bit_builder: derives frame slots 9 and 8 from the data byte and mode
module tx_bit_builder
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  output logic       bit9,
  output logic       bit8
);
  mode_e mode;
  logic p7, p8;
  always_comb begin
    mode = mode_e'({eight, pen});
    p7 = ^data[6:0] ^ ohel;
    p8 = ^data ^ ohel;
    bit9 = mode == MODE_8P ? p8 : STOP_LVL;
    bit8 = mode == MODE_7N ? STOP_LVL : mode == MODE_7P ? p7 : data[7];
  end
endmodule

// File: rtl/tx_engine.sv
// tx_engine: UART transmitter shifting an 11-bit frame LSB-first at a programmable bit period
module tx_engine #(
  parameter int BAUD_W = uart_pkg::BAUD_W,
  parameter int FRAME_W = uart_pkg::FRAME_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        data,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_val,
  output logic              tx,
  output logic              tx_rdy,
  output logic              done
);
  uart_pkg::state_e state, state_n;
  logic [FRAME_W-1:0] shift, shift_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_n, period;
  logic done_n, bit9, bit8, term, last;
  tx_bit_builder u_bits (
    .data(data),
    .eight(eight),
    .pen(pen),
    .ohel(ohel),
    .bit9(bit9),
    .bit8(bit8)
  );
  assign tx = shift[0];
  assign tx_rdy = state == uart_pkg::IDLE;
  // >= keeps a live baud_val decrease from stranding the counter above terminal
  always_comb begin
    period = baud_val == '0 ? BAUD_W'(1) : baud_val;
    term = baud_cnt >= period - BAUD_W'(1);
    last = bit_cnt == 4'(FRAME_W - 1);
    state_n = state;
    shift_n = shift;
    bit_cnt_n = bit_cnt;
    baud_cnt_n = baud_cnt;
    done_n = 1'b0;
    if (state == uart_pkg::IDLE) begin
      if (load) begin
        state_n = uart_pkg::SHIFT;
        shift_n = {uart_pkg::STOP_LVL, bit9, bit8, data[6:0], uart_pkg::START_LVL};
        bit_cnt_n = '0;
        baud_cnt_n = '0;
      end
    end else if (term) begin
      shift_n = {uart_pkg::IDLE_LVL, shift[FRAME_W-1:1]};
      baud_cnt_n = '0;
      bit_cnt_n = last ? 4'd0 : bit_cnt + 4'd1;
      state_n = last ? uart_pkg::IDLE : uart_pkg::SHIFT;
      done_n = last;
    end else begin
      baud_cnt_n = baud_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= uart_pkg::IDLE;
      shift <= '1;
      bit_cnt <= '0;
      baud_cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      bit_cnt <= bit_cnt_n;
      baud_cnt <= baud_cnt_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_tx_engine.sv
// tb_tx_engine: table-driven, hand-sequenced and randomized checks of tx_engine
module tb_tx_engine;
  logic clk, reset, load, eight, pen, ohel, tx, tx_rdy, done;
  logic [7:0] data;
  logic [19:0] baud_val;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] d;
    logic e, p, o;
    int baud;
    logic [10:0] f;
  } vec_t;
  vec_t tbl[4];

  tx_engine dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .eight(eight),
    .pen(pen), .ohel(ohel), .baud_val(baud_val), .tx(tx), .tx_rdy(tx_rdy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, x, $time);
    end
  endtask

  // Frame from the bit-slot rules: parity makes the count of ones even (ohel=0) or odd (ohel=1)
  function automatic logic [10:0] model(input logic [7:0] d, input logic e, input logic p, input logic o);
    int ones7, ones8;
    logic p7, p8, b8, b9;
    ones7 = $countones(d[6:0]);
    ones8 = $countones(d);
    p7 = ((ones7 + int'(o)) % 2) != 0;
    p8 = ((ones8 + int'(o)) % 2) != 0;
    b8 = e ? d[7] : (p ? p7 : 1'b1);
    b9 = (e && p) ? p8 : 1'b1;
    return {1'b1, b9, b8, d[6:0], 1'b0};
  endfunction

  task automatic launch(input logic [7:0] d, input logic e, input logic p, input logic o, input int bv);
    data = d; eight = e; pen = p; ohel = o; baud_val = 20'(bv); load = 1'b1;
    @(negedge clk);
  endtask

  // Called one cycle after the load edge; returns in the done cycle
  task automatic wait_frame(input logic [10:0] f, input int b, input bit inject);
    for (int i = 1; i <= 11 * b; i++) begin
      chk("tx_bit", tx, f[(i-1)/b]);
      chk("rdy_busy", tx_rdy, 1'b0);
      chk("done_busy", done, 1'b0);
      if (inject && i == 3 * b + 1) begin
        load = 1'b1; data = 8'h00; eight = 1'b0; pen = 1'b0;
      end else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("rdy_done", tx_rdy, 1'b1);
    chk("tx_stop", tx, 1'b1);
  endtask

  task automatic idle_check(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1'b1);
      chk("idle_rdy", tx_rdy, 1'b1);
      chk("idle_done", done, 1'b0);
    end
  endtask

  initial begin
    tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 4, 11'b10010101010};
    tbl[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 2, 11'b11110000010};
    tbl[2] = '{8'h7F, 1'b0, 1'b0, 1'b0, 0, 11'b11111111110};
    tbl[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 3, 11'b11101001010};
    reset = 1'b1; load = 1'b0; data = '0; eight = 1'b0; pen = 1'b0; ohel = 1'b0; baud_val = '0;
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_rdy", tx_rdy, 1'b1);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_check(20);
    for (int k = 0; k < 4; k++) begin
      launch(tbl[k].d, tbl[k].e, tbl[k].p, tbl[k].o, tbl[k].baud);
      wait_frame(tbl[k].f, tbl[k].baud == 0 ? 1 : tbl[k].baud, 1'b0);
      idle_check(2);
    end
    // ignored mid-frame load, then a back-to-back load in the done cycle
    launch(8'hC3, 1'b1, 1'b0, 1'b0, 3);
    wait_frame(11'b11110000110, 3, 1'b1);
    launch(8'h00, 1'b1, 1'b0, 1'b0, 3);
    wait_frame(11'b11000000000, 3, 1'b0);
    idle_check(3);
    // async reset during bit 5
    launch(tbl[0].d, tbl[0].e, tbl[0].p, tbl[0].o, tbl[0].baud);
    load = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_tx", tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_tx", tx, 1'b1);
    chk("async_rdy", tx_rdy, 1'b1);
    @(negedge clk);
    chk("rst_hold_done", done, 1'b0);
    reset = 1'b0;
    idle_check(12);
    launch(tbl[1].d, tbl[1].e, tbl[1].p, tbl[1].o, tbl[1].baud);
    wait_frame(tbl[1].f, tbl[1].baud, 1'b0);
    // randomized frames against the slot-rule model
    for (int r = 0; r < 25; r++) begin
      logic [7:0] d;
      logic e, p, o;
      int bv, gap;
      d = 8'($urandom); e = 1'($urandom); p = 1'($urandom); o = 1'($urandom);
      bv = int'($urandom_range(0, 5));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle_check(gap);
      launch(d, e, p, o, bv);
      wait_frame(model(d, e, p, o), bv == 0 ? 1 : bv, 1'b0);
    end
    idle_check(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
